// File: rtl/eh2_posit_pkg.sv
// Shared types and sizing for the EH2 posit operand path.
// The decoded-operand layout and scheduler state encoding are defined here.
package eh2_posit_pkg;

    localparam int unsigned POSIT_LEN   = 16;
    localparam int unsigned ES          = 2;
    localparam int unsigned REGIME_BW   = $clog2(POSIT_LEN);
    localparam int unsigned FRACTION_BW = POSIT_LEN - ES - 3;
    localparam int unsigned NUM_THR     = 2;

    typedef struct packed {
        logic                   sign;
        logic [REGIME_BW-1:0]   regime;
        logic [ES-1:0]          exponent;
        logic [FRACTION_BW-1:0] fraction;
        logic                   is_special;
    } posit_dec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEC_A = 2'd1,
        DEC_B = 2'd2,
        HOLD  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/eh2_posit_decode.sv
// Combinational posit field extractor: sign, two's-complement regime, exponent, fraction.
// Zero and NaR are flagged is_special with the remaining fields cleared.
module eh2_posit_decode
    import eh2_posit_pkg::*;
(
    input  logic [POSIT_LEN-1:0] posit_in,
    output posit_dec_t           dec_out
);

    logic [POSIT_LEN-2:0]      body;
    logic [ES+FRACTION_BW-1:0] tail;
    logic                      lead;
    logic                      stop;
    logic                      special;
    int unsigned               run;

    always_comb begin
        dec_out = '0;
        body    = posit_in[POSIT_LEN-1] ? (~posit_in[POSIT_LEN-2:0] + (POSIT_LEN-1)'(1))
                                        : posit_in[POSIT_LEN-2:0];
        special = (posit_in[POSIT_LEN-2:0] == '0);
        lead    = body[POSIT_LEN-2];
        run     = 0;
        stop    = 1'b0;
        for (int unsigned i = 0; i < POSIT_LEN - 1; i++) begin
            if (!stop && (body[POSIT_LEN-2-i] == lead)) begin
                run = run + 1;
            end else begin
                stop = 1'b1;
            end
        end
        // The regime always occupies at least two body bits, so the exponent/fraction
        // window starts at body[POSIT_LEN-4] and is shifted by the extra run length.
        tail = body[ES+FRACTION_BW-1:0] << (run - 1);

        dec_out.sign       = posit_in[POSIT_LEN-1];
        dec_out.is_special = special;
        if (!special) begin
            dec_out.regime   = lead ? REGIME_BW'(run - 1) : REGIME_BW'(-int'(run));
            dec_out.exponent = tail[ES+FRACTION_BW-1 -: ES];
            dec_out.fraction = tail[FRACTION_BW-1:0];
        end
    end

endmodule

// File: rtl/eh2_posit_operand_sched.sv
// Time-shares one posit decoder between two hart threads: accepts an operand pair,
// decodes A then B, and holds the decoded pair until the execute stage takes it.
module eh2_posit_operand_sched
    import eh2_posit_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_THR-1:0]             req_vld,
    output logic [NUM_THR-1:0]             req_rdy,
    input  logic [NUM_THR*POSIT_LEN-1:0]   req_opa,
    input  logic [NUM_THR*POSIT_LEN-1:0]   req_opb,
    input  logic [NUM_THR-1:0]             flush,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic                           out_tid,
    output posit_dec_t                     out_a,
    output posit_dec_t                     out_b
);

    sched_state_e         state_q, state_d;
    logic                 rr_q, rr_d;
    logic                 tid_q, tid_d;
    logic [POSIT_LEN-1:0] opa_q, opa_d;
    logic [POSIT_LEN-1:0] opb_q, opb_d;
    posit_dec_t           out_a_q, out_a_d;
    posit_dec_t           out_b_q, out_b_d;

    logic [POSIT_LEN-1:0] dec_in;
    posit_dec_t           dec_res;
    logic [NUM_THR-1:0]   cand;
    logic [NUM_THR-1:0]   grant;
    logic                 gnt_tid;
    logic                 arb_en;
    logic                 own_flush;

    eh2_posit_decode u_decode (
        .posit_in (dec_in),
        .dec_out  (dec_res)
    );

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        tid_d     = tid_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        out_a_d   = out_a_q;
        out_b_d   = out_b_q;
        dec_in    = '0;
        grant     = '0;
        gnt_tid   = 1'b0;
        own_flush = flush[tid_q];
        cand      = req_vld & ~flush;
        // A flush of the held pair wins over the handshake, so no new grant in that cycle.
        arb_en    = !rst && ((state_q == IDLE) ||
                             ((state_q == HOLD) && out_rdy && !own_flush));

        if (arb_en) begin
            if (cand[rr_q]) begin
                grant[rr_q] = 1'b1;
                gnt_tid     = rr_q;
            end else if (cand[~rr_q]) begin
                grant[~rr_q] = 1'b1;
                gnt_tid      = ~rr_q;
            end
        end

        if (|grant) begin
            tid_d = gnt_tid;
            rr_d  = ~gnt_tid;
            opa_d = gnt_tid ? req_opa[2*POSIT_LEN-1:POSIT_LEN] : req_opa[POSIT_LEN-1:0];
            opb_d = gnt_tid ? req_opb[2*POSIT_LEN-1:POSIT_LEN] : req_opb[POSIT_LEN-1:0];
        end

        case (state_q)
            IDLE: begin
                if (|grant) state_d = DEC_A;
            end
            DEC_A: begin
                dec_in  = opa_q;
                out_a_d = dec_res;
                state_d = own_flush ? IDLE : DEC_B;
            end
            DEC_B: begin
                dec_in  = opb_q;
                out_b_d = dec_res;
                state_d = own_flush ? IDLE : HOLD;
            end
            HOLD: begin
                if (own_flush)    state_d = IDLE;
                else if (out_rdy) state_d = (|grant) ? DEC_A : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            tid_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            tid_q   <= tid_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
        end
    end

    assign req_rdy = grant;
    assign out_vld = (state_q == HOLD);
    assign out_tid = tid_q;
    assign out_a   = out_a_q;
    assign out_b   = out_b_q;

endmodule
